taxi_eth_mac_rx_stats: RTL and testbench

Receive-side statistics block that sits directly downstream of the 1G RGMII MAC in the `rx_clk` domain. It passively monitors the MAC receive AXI stream and the receive status pulses, then classifies and counts frames in saturating counters. On request it snapshots all counters into shadow registers, optionally clearing them, so software reads a coherent set.

---
 rtl/taxi_eth_mac_rx_stats.sv | 148 ++++++++++++++
 tb/tb_taxi_eth_mac_rx_stats.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_eth_mac_rx_stats.sv
// Receive statistics for the 1G MAC rx stream: classifies frames into
// saturating counters and snapshots them into shadows for coherent reads.
//
// state | meaning
// SYNC  | after reset; drop beats until a tlast so a partial frame is never counted
// IDLE  | between frames; next beat starts a frame (or is a 1-byte frame)
// FRAME | inside a frame; counting beats until tlast
module taxi_eth_mac_rx_stats #(
   parameter int CNT_W         = 32,
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mon_tvalid,
   input  logic        mon_tready,
   input  logic        mon_tlast,
   input  logic        mon_tuser,
   input  logic        rx_error_bad_fcs,
   input  logic        stat_rx_lfc_pkt,
   input  logic        stat_rx_pfc_pkt,
   input  logic        snap_req,
   input  logic        snap_clear,
   input  logic        rd_en,
   input  logic [2:0]  rd_addr,
   output logic [63:0] rd_data,
   output logic        rd_valid
);

   typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

   localparam int             SUM_W   = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [15:0]    MIN_LEN = 16'(MIN_FRAME_LEN);
   localparam logic [15:0]    MAX_LEN = 16'(MAX_FRAME_LEN);

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [CNT_W-1:0]  cnt_q [8];
   logic [CNT_W-1:0]  cnt_d [8];
   logic [CNT_W-1:0]  shadow_q [8];
   logic [CNT_W-1:0]  shadow_d [8];
   logic [63:0]       rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic              beat;
   logic              eof;
   logic [15:0]       frame_len;
   logic [15:0]       len_inc;
   logic [7:0]        ev;
   logic              frame_ok;
   logic [CNT_W-1:0]  base [8];
   logic [SUM_W-1:0]  byte_sum;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      eof       = 1'b0;
      frame_len = '0;
      beat      = mon_tvalid & mon_tready;
      len_inc   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
      case (state_q)
         SYNC: begin
            if (beat && mon_tlast) state_d = IDLE;
         end
         IDLE: begin
            if (beat) begin
               if (mon_tlast) begin
                  eof       = 1'b1;
                  frame_len = 16'd1;
               end else begin
                  len_d   = 16'd1;
                  state_d = FRAME;
               end
            end
         end
         FRAME: begin
            if (beat) begin
               if (mon_tlast) begin
                  eof       = 1'b1;
                  frame_len = len_inc;
                  len_d     = '0;
                  state_d   = IDLE;
               end else begin
                  len_d = len_inc;
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   // Exactly one frame class fires per tlast; bytes_ok (index 1) is handled as an add.
   always_comb begin
      frame_ok = eof && !mon_tuser && (frame_len >= MIN_LEN) && (frame_len <= MAX_LEN);
      ev       = '0;
      ev[0]    = frame_ok;
      ev[2]    = eof && mon_tuser;
      ev[3]    = rx_error_bad_fcs;
      ev[4]    = eof && !mon_tuser && (frame_len < MIN_LEN);
      ev[5]    = eof && !mon_tuser && (frame_len >= MIN_LEN) && (frame_len > MAX_LEN);
      ev[6]    = stat_rx_lfc_pkt;
      ev[7]    = stat_rx_pfc_pkt;
      for (int i = 0; i < 8; i++) begin
         base[i]     = (snap_req && snap_clear) ? '0 : cnt_q[i];
         cnt_d[i]    = (ev[i] && base[i] != CNT_MAX) ? base[i] + CNT_W'(1) : base[i];
         shadow_d[i] = snap_req ? cnt_q[i] : shadow_q[i];
      end
      byte_sum = {1'b0, base[1]} + SUM_W'(frame_len);
      if (frame_ok) cnt_d[1] = byte_sum[CNT_W] ? CNT_MAX : byte_sum[CNT_W-1:0];
   end

   // Reads see shadow_q, so a read coinciding with a snapshot returns the old set.
   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = rd_data_q;
      if (rd_en) begin
         rd_data_d              = '0;
         rd_data_d[CNT_W-1:0]   = shadow_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= SYNC;
         len_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i]    <= cnt_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_taxi_eth_mac_rx_stats.sv
// Directed bench for taxi_eth_mac_rx_stats with CNT_W=16 so bytes_ok saturation is reachable.
module tb_taxi_eth_mac_rx_stats;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mon_tvalid, mon_tready, mon_tlast, mon_tuser;
   logic        rx_error_bad_fcs, stat_rx_lfc_pkt, stat_rx_pfc_pkt;
   logic        snap_req, snap_clear, rd_en;
   logic [2:0]  rd_addr;
   logic [63:0] rd_data;
   logic        rd_valid;

   int total = 0;
   int bad   = 0;

   taxi_eth_mac_rx_stats #(.CNT_W(16), .MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
      .clk(clk), .rst_n(rst_n),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_tuser(mon_tuser),
      .rx_error_bad_fcs(rx_error_bad_fcs), .stat_rx_lfc_pkt(stat_rx_lfc_pkt),
      .stat_rx_pfc_pkt(stat_rx_pfc_pkt), .snap_req(snap_req), .snap_clear(snap_clear),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; mon_tuser = 0;
      rx_error_bad_fcs = 0; stat_rx_lfc_pkt = 0; stat_rx_pfc_pkt = 0;
      snap_req = 0; snap_clear = 0; rd_en = 0; rd_addr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (3) tick();
      rst_n = 1;
   endtask

   task automatic beat(input bit last, input bit user, input bit gaps);
      if (gaps && $urandom_range(0, 3) == 0) begin
         int n;
         n = $urandom_range(1, 2);
         for (int k = 0; k < n; k++) begin
            mon_tvalid = 1'($urandom_range(0, 1));
            mon_tready = !mon_tvalid;
            mon_tlast  = 1'($urandom_range(0, 1));
            mon_tuser  = 1'b1;
            tick();
         end
      end
      mon_tvalid = 1; mon_tready = 1; mon_tlast = last; mon_tuser = user;
      tick();
      mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; mon_tuser = 0;
   endtask

   task automatic frame(input int len, input bit user, input bit gaps);
      for (int b = 1; b <= len; b++) beat(b == len, user, gaps);
   endtask

   task automatic snapshot(input bit clear);
      snap_req = 1; snap_clear = clear;
      tick();
      snap_req = 0; snap_clear = 0;
   endtask

   task automatic rd(input int addr, output logic [63:0] d);
      rd_en = 1; rd_addr = 3'(addr);
      tick();
      rd_en = 0;
      d = rd_data;
   endtask

   task automatic test_reset();
      logic [63:0] d;
      idle_inputs();
      rst_n = 0;
      rd_en = 1;
      repeat (3) tick();
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
      rd_en = 0;
      rst_n = 1;
      for (int a = 0; a < 8; a++) begin
         rd(a, d);
         total++;
         if (d !== 64'h0) begin bad++; $display("FAIL reset_shadow%0d: got %0h want 0", a, d); end
      end
   endtask

   task automatic test_status_pulses();
      logic [63:0] d;
      int idx [4] = '{3, 6, 7, 0};
      logic [63:0] exp [4] = '{64'd3, 64'd5, 64'd7, 64'd0};
      rx_error_bad_fcs = 1;
      tick();
      rx_error_bad_fcs = 0;
      beat(1, 0, 0);
      for (int i = 0; i < 7; i++) begin
         rx_error_bad_fcs = (i < 2);
         stat_rx_lfc_pkt  = (i < 5);
         stat_rx_pfc_pkt  = 1;
         tick();
      end
      rx_error_bad_fcs = 0; stat_rx_lfc_pkt = 0; stat_rx_pfc_pkt = 0;
      snapshot(1);
      for (int i = 0; i < 4; i++) begin
         rd(idx[i], d);
         total++;
         if (d !== exp[i]) begin bad++; $display("FAIL status_cnt%0d: got %0d want %0d", idx[i], d, exp[i]); end
      end
   endtask

   task automatic test_sync_discard();
      logic [63:0] d;
      for (int b = 0; b < 10; b++) beat(0, 0, 0);
      do_reset();
      for (int b = 0; b < 20; b++) beat(0, 0, 0);
      frame(64, 0, 0);
      snapshot(0);
      rd(0, d);
      total++;
      if (d !== 64'd0) begin bad++; $display("FAIL sync_frames_ok: got %0d want 0", d); end
      rd(4, d);
      total++;
      if (d !== 64'd0) begin bad++; $display("FAIL sync_runt: got %0d want 0", d); end
      frame(64, 0, 0);
      snapshot(1);
      rd(0, d);
      total++;
      if (d !== 64'd1) begin bad++; $display("FAIL sync_good_frames: got %0d want 1", d); end
      rd(1, d);
      total++;
      if (d !== 64'd64) begin bad++; $display("FAIL sync_good_bytes: got %0d want 64", d); end
   endtask

   task automatic test_classify();
      frame(60, 0, 1);
      frame(64, 0, 1);
      frame(1518, 0, 1);
      frame(1519, 0, 1);
      frame(100, 1, 1);
      frame(1, 0, 1);
      snapshot(1);
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp [8] = '{64'd2, 64'd1582, 64'd1, 64'd0, 64'd2, 64'd1, 64'd0, 64'd0};
      for (int a = 0; a < 8; a++) begin
         rd_en = 1; rd_addr = 3'(a);
         tick();
         total++;
         if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %0b want 1", a, rd_valid); end
         total++;
         if (rd_data !== exp[a]) begin bad++; $display("FAIL b2b_data%0d: got %0h want %0h", a, rd_data, exp[a]); end
      end
      rd_en = 0;
      tick();
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %0b want 0", rd_valid); end
      total++;
      if (rd_data !== exp[7]) begin bad++; $display("FAIL b2b_hold: got %0h want %0h", rd_data, exp[7]); end
   endtask

   task automatic test_snap_clear_event();
      logic [63:0] d;
      for (int f = 0; f < 4; f++) frame(64, 0, 0);
      for (int b = 0; b < 63; b++) beat(0, 0, 0);
      mon_tvalid = 1; mon_tready = 1; mon_tlast = 1;
      snap_req = 1; snap_clear = 1;
      tick();
      idle_inputs();
      rd(0, d);
      total++;
      if (d !== 64'd4) begin bad++; $display("FAIL clr_shadow_frames: got %0d want 4", d); end
      rd(1, d);
      total++;
      if (d !== 64'd256) begin bad++; $display("FAIL clr_shadow_bytes: got %0d want 256", d); end
      snapshot(0);
      rd(0, d);
      total++;
      if (d !== 64'd1) begin bad++; $display("FAIL clr_live_frames: got %0d want 1", d); end
      rd(1, d);
      total++;
      if (d !== 64'd64) begin bad++; $display("FAIL clr_live_bytes: got %0d want 64", d); end
      frame(64, 0, 0);
      snap_req = 1; rd_en = 1; rd_addr = 0;
      tick();
      snap_req = 0; rd_en = 0;
      total++;
      if (rd_data !== 64'd1) begin bad++; $display("FAIL rd_snap_same_cycle: got %0d want 1", rd_data); end
      rd(0, d);
      total++;
      if (d !== 64'd2) begin bad++; $display("FAIL rd_after_snap: got %0d want 2", d); end
   endtask

   task automatic test_saturation();
      logic [63:0] d;
      snapshot(1);
      for (int f = 0; f < 44; f++) frame(1500, 0, 0);
      snapshot(0);
      rd(1, d);
      total++;
      if (d !== 64'hFFFF) begin bad++; $display("FAIL sat_bytes: got %0h want ffff", d); end
      rd(0, d);
      total++;
      if (d !== 64'd44) begin bad++; $display("FAIL sat_frames: got %0d want 44", d); end
      frame(64, 0, 0);
      snapshot(0);
      rd(1, d);
      total++;
      if (d !== 64'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h want ffff", d); end
      snapshot(1);
      frame(64, 0, 0);
      snapshot(0);
      rd(1, d);
      total++;
      if (d !== 64'd64) begin bad++; $display("FAIL sat_restart: got %0d want 64", d); end
   endtask

   initial begin
      test_reset();
      test_status_pulses();
      test_sync_discard();
      test_classify();
      test_back_to_back();
      test_snap_clear_event();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
